display_scan: RTL and testbench
===============================

# display_scan

Time-multiplexed scan controller for a bank of common-anode 7-segment digits. It latches a multi-digit hex value and drives one digit at a time. Each digit gets a guard (all-off) interval before it is driven, to suppress ghosting. Value updates are committed only at frame boundaries, so the display never tears. It sits between the processor's output register and the board pins, and feeds each selected nibble through the existing `display` hex-to-segment decoder.

## Interface

- `NDIG`, 4: number of digits scanned (2..8).
- `REFRESH_DIV`, 50000: cycles each digit is driven (≥2).
- `GUARD`, 16: all-off cycles before each digit is driven (≥1).

- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state to reset values immediately.
- `valor` in 4*NDIG: hex value; nibble k drives digit k (digit 0 = least significant).
- `load` in 1: one-cycle strobe; captures `valor`.
- `blank_zeros` in 1: level; 1 = blank leading zero digits.
- `an` out NDIG: digit enables, active-low, one-hot-low while driving.
- `seg` out 7: segment pattern, active-low, bit order as produced by `display`.
- `pend` out 1: captured value waiting for frame-boundary commit.
- `frame_done` out 1: one-cycle pulse when the last digit slot ends.

## Operation

- Registers: `shadow` (4*NDIG), `shown` (4*NDIG), `idx` (digit index, clog2(NDIG) bits), `cnt` (slot counter), `state`, `pend`.
- FSM states:
  - **GUARD**: `an` all 1, `seg` 7'b1111111. After `GUARD` cycles, go to DRIVE.
  - **DRIVE**: `an[idx]`=0, all other `an` bits 1. `seg` = decode(`shown[4*idx+:4]`), or 7'b1111111 if idx is blanked. After `REFRESH_DIV` cycles, go to GUARD with idx+1.
- Wrap: idx NDIG-1 → 0. The leaving cycle pulses `frame_done`.
- Commit: on the cycle DRIVE→GUARD with idx wrapping to 0, if `pend`=1 then `shown`←`shadow` and `pend`←0.
- `load`=1 (not on a commit cycle): `shadow`←`valor`, `pend`←1. A later load before commit overwrites `shadow`; last load wins.
- `load` on the commit cycle: `valor` goes straight to `shown`, `pend`←0. Any older shadow contents are discarded.
- Leading-zero blanking, evaluated on `shown` combinationally:
  - Digit k>0 is blanked when `blank_zeros`=1 and nibbles k..NDIG-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit still occupies its slot, with `an[idx]`=0 and `seg` all off, so the frame period is unchanged.
- Reset mid-frame: the scan restarts at GUARD, idx 0, `shown`=0, and any pending value is lost.

## Timing

- Reset values:
  - `an` = all 1s, `seg` = 7'b1111111, `pend` = 0, `frame_done` = 0.
  - `shown` = `shadow` = 0, `idx` = 0, `cnt` = 0, state GUARD.
- `an`, `seg`, `frame_done` and `pend` are registered. `seg` reflects the new idx in the same cycle `an` does, with no one-cycle mismatch.
- Slot length: GUARD+REFRESH_DIV cycles. Frame length: NDIG*(GUARD+REFRESH_DIV) cycles.
- First DRIVE of digit 0 starts `GUARD` cycles after reset release.
- `pend` rises the cycle after `load`. Worst-case commit latency is one full frame.
- `cnt` width is clog2(max(GUARD, REFRESH_DIV)). It counts 0..N-1 and resets on every state change.

## Structure

- Shared package `display_pkg`:
  - state encoding (GUARD, DRIVE);
  - constant `SEG_OFF` = 7'b1111111;
  - function `lz_mask(value, blank_zeros)` returning the NDIG-bit blank mask.
- Sub-module: one instance of `display` (4-bit in, 7-bit out), driven by `shown[4*idx+:4]`. Its output is muxed with `SEG_OFF`, then registered.
- Estimated 150–250 lines of RTL.

## Test plan

Parameters for all scenarios: NDIG=4, REFRESH_DIV=4, GUARD=1.

- **Reset**: assert `reset` asynchronously mid-DRIVE → `an`=4'b1111 and `seg`=7'b1111111 before the next edge. After release, first `an`=4'b1110 appears 1 cycle later.
- **Scan order**: load 16'h1A3F, wait one frame.
  - Digits 0..3 show 7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001 in turn, 4 cycles each.
  - 1 guard cycle with `an`=4'b1111 between digits.
  - `frame_done` pulses every 20 cycles.
- **Tear-free commit**: load 16'h1111 mid-frame, then 16'h2222 two cycles later.
  - `pend`=1 until the wrap.
  - `shown` never equals 16'h1111; the next frame shows all 2s.
  - `pend`=0 after the commit.
- **Load on commit cycle**: pulse `load` with 16'hBEEF exactly on the `frame_done` cycle → the next frame shows BEEF, and `pend` stays 0.
- **Leading-zero blanking**: `blank_zeros`=1, value 16'h0050.
  - Digits 3 and 2 have `seg`=7'b1111111 with their anodes still active.
  - Digit 1 shows 7'b0010010; digit 0 shows 7'b1000000.
  - Value 16'h0000 shows only digit 0 as 7'b1000000.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam int MAX_DIG = 8;

  // Bit k set when digit k is a leading zero to blank; digit 0 is always shown.
  function automatic logic [MAX_DIG-1:0] lz_mask(input logic [4*MAX_DIG-1:0] value,
                                                 input logic blank_zeros,
                                                 input int ndig);
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int k = MAX_DIG - 1; k >= 1; k--) begin
      if (k < ndig) begin
        all_zero   = all_zero && (value[4*k +: 4] == 4'h0);
        lz_mask[k] = blank_zeros && all_zero;
      end
    end
  endfunction

endpackage

// File: rtl/display.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module display (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_hex)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Scan controller: guard slot then drive slot per digit, with tear-free value
// commits at frame boundaries and optional leading-zero blanking.
module display_scan
  import display_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4*NDIG-1:0]   valor,
  input  logic                load,
  input  logic                blank_zeros,
  output logic [NDIG-1:0]     an,
  output logic [6:0]          seg,
  output logic                pend,
  output logic                frame_done,
  output logic                dbg_state
);

  localparam int CNT_MAX = (GUARD > REFRESH_DIV) ? GUARD : REFRESH_DIV;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DRIVE_PRE  = CW'(REFRESH_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*NDIG-1:0]   r_shadow;
  logic [4*NDIG-1:0]   r_shown;

  logic [3:0]          w_nib;
  logic [6:0]          w_dec;
  logic [MAX_DIG-1:0]  w_mask_full;
  logic [NDIG-1:0]     w_mask;
  logic [6:0]          w_seg_drv;
  logic [NDIG-1:0]     w_an_drv;
  logic                w_wrap;

  // idx and shown only change on DRIVE->GUARD, so the decode of the current
  // digit is valid for whatever is registered into seg while entering or
  // staying in DRIVE; seg and an therefore switch on the same edge.
  assign w_nib       = r_shown[{r_idx, 2'b00} +: 4];
  assign w_mask_full = lz_mask(32'(r_shown), blank_zeros, NDIG);
  assign w_mask      = w_mask_full[NDIG-1:0];
  assign w_seg_drv   = w_mask[r_idx] ? SEG_OFF : w_dec;
  assign w_an_drv    = ~(NDIG'(1) << r_idx);
  assign w_wrap      = (r_state == ST_DRIVE) && (r_cnt == DRIVE_LAST) && (r_idx == IDX_LAST);
  assign dbg_state   = r_state;

  display u_display (
    .i_hex (w_nib),
    .o_seg (w_dec)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_GUARD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_shown    <= '0;
      an         <= '1;
      seg        <= SEG_OFF;
      pend       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Registered one cycle early so the pulse coincides with the commit cycle.
      frame_done <= (r_state == ST_DRIVE) && (r_idx == IDX_LAST) && (r_cnt == DRIVE_PRE);

      case (r_state)
        ST_GUARD: begin
          if (r_cnt == GUARD_LAST) begin
            r_state <= ST_DRIVE;
            r_cnt   <= '0;
            an      <= w_an_drv;
            seg     <= w_seg_drv;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            an      <= '1;
            seg     <= SEG_OFF;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == DRIVE_LAST) begin
            r_state <= ST_GUARD;
            r_cnt   <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            an      <= '1;
            seg     <= SEG_OFF;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            an      <= w_an_drv;
            seg     <= w_seg_drv;
          end
        end
        default: begin
          r_state <= ST_GUARD;
          r_cnt   <= '0;
          an      <= '1;
          seg     <= SEG_OFF;
        end
      endcase

      // A load landing on the commit cycle bypasses the shadow entirely.
      if (w_wrap && load) begin
        r_shown <= valor;
        pend    <= 1'b0;
      end else if (w_wrap && pend) begin
        r_shown <= r_shadow;
        pend    <= 1'b0;
      end else if (load) begin
        r_shadow <= valor;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan with NDIG=4, REFRESH_DIV=4, GUARD=1 (20-cycle frames).
module tb_display_scan;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] valor;
  logic        load;
  logic        blank_zeros;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        pend;
  logic        frame_done;
  logic        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  // {pend, frame_done, an[3:0], seg[6:0]} expected for each monitored cycle
  logic [12:0] exp_q[$];

  display_scan #(.NDIG(4), .REFRESH_DIV(4), .GUARD(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .valor       (valor),
    .load        (load),
    .blank_zeros (blank_zeros),
    .an          (an),
    .seg         (seg),
    .pend        (pend),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h5: return 7'b0010010;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hE: return 7'b0000110;
      4'hF: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Frame cycle c: c%5==0 is the guard slot of digit c/5, the rest drive it.
  task automatic push_frame(input logic [15:0] v, input logic blank,
                            input int plo, input int phi);
    for (int c = 0; c < 20; c++) begin
      int d;
      logic [3:0] a;
      logic [6:0] sg;
      logic p;
      d = c / 5;
      if (c % 5 == 0) begin
        a  = 4'hF;
        sg = 7'h7F;
      end else begin
        a  = ~(4'(1) << d);
        if (blank && d > 0 && ((v >> (4 * d)) == 16'h0)) sg = 7'h7F;
        else sg = seg_of(v[4*d +: 4]);
      end
      p = (c >= plo) && (c <= phi);
      exp_q.push_back({p, (c == 19), a, sg});
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        cmp("scan_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        cmp("scan", {19'd0, pend, frame_done, an, seg}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin : stim
    bit seen;
    reset = 1'b1;
    valor = '0;
    load = 1'b0;
    blank_zeros = 1'b0;
    step(2);
    cmp("rst_an", an, 4'hF);
    cmp("rst_seg", seg, 7'h7F);
    cmp("rst_pend", pend, 1'b0);
    cmp("rst_frame_done", frame_done, 1'b0);

    reset = 1'b0;
    step(1);
    cmp("first_an", an, 4'b1110);
    cmp("first_seg", seg, 7'b1000000);

    valor = 16'h1A3F;
    load = 1'b1;
    step(1);
    load = 1'b0;
    cmp("pend_rise", pend, 1'b1);

    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1);
      if (frame_done) seen = 1;
    end
    cmp("frame0_done_seen", seen, 1'b1);

    push_frame(16'h1A3F, 1'b0, 20, 0);
    push_frame(16'h1A3F, 1'b0, 6, 19);
    push_frame(16'h2222, 1'b0, 20, 0);
    push_frame(16'hBEEF, 1'b0, 20, 0);
    push_frame(16'h0050, 1'b1, 20, 0);
    push_frame(16'h0000, 1'b1, 20, 0);
    step(1);
    mon_en = 1'b1;
    step(20);

    step(5);
    valor = 16'h1111;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    valor = 16'h2222;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(12);

    step(19);
    valor = 16'hBEEF;
    load = 1'b1;
    step(1);
    load = 1'b0;

    step(19);
    valor = 16'h0050;
    load = 1'b1;
    blank_zeros = 1'b1;
    step(1);
    load = 1'b0;

    step(19);
    valor = 16'h0000;
    load = 1'b1;
    step(1);
    load = 1'b0;

    step(20);
    mon_en = 1'b0;
    cmp("queue_drained", 32'(exp_q.size()), 32'd0);

    blank_zeros = 1'b0;
    valor = 16'h1234;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    cmp("pre_rst_an", an, 4'b1110);
    cmp("pre_rst_pend", pend, 1'b1);
    #2 reset = 1'b1;
    #1;
    cmp("async_rst_an", an, 4'hF);
    cmp("async_rst_seg", seg, 7'h7F);
    cmp("async_rst_pend", pend, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    step(1);
    cmp("restart_an", an, 4'b1110);
    cmp("restart_seg_shown0", seg, 7'b1000000);
    cmp("restart_pend", pend, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
